// File: rtl/uart_rx_param.sv
// uart_rx_param
// ---------------------------------------------------------------------------
// Oversampling UART receiver with a runtime baud divisor, 16 samples per bit,
// a 3-sample majority vote, false-start rejection, configurable parity and
// stop bits, and a valid/ready output holding register.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   rx              serial line (asynchronous, idle high)
//   baud_div        clk cycles per oversample tick (0 behaves as 1)
//   parity_mode     00/11 none, 01 even, 10 odd (latched at frame start)
//   two_stop        1 = two stop bits (latched at frame start)
//   rx_data         received word, stable while rx_valid is high
//   rx_valid        holding register full
//   rx_ready        consumer accepts when rx_valid && rx_ready on a clk edge
//   parity_err      parity mismatch of the held word (qualified by rx_valid)
//   frame_err       a stop bit of the held word was sampled low
//   overrun         1-clk pulse: a finished frame was dropped (register full)
//   busy            receiver FSM is not in IDLE
//
// Handshake: a word transfers on every clk edge where rx_valid and rx_ready
// are both high; rx_valid never drops without such a transfer, and rx_data
// and the error flags never change while rx_valid is high.
// ---------------------------------------------------------------------------
module uart_rx_param #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16,
  parameter int OSR       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [3:0] S_LAST = 4'(OSR - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP1  = 3'd4;
  localparam logic [2:0] ST_STOP2  = 3'd5;

  // Two-flop synchroniser, idle (1) during reset.
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Free-running tick generator. The divisor is captured at each wrap so a
  // new baud_div only changes the period from the next wrap onwards.
  logic [DIV_W-1:0] tick_cnt;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_eff;
  logic             tick;

  assign div_eff = (div_q == '0) ? DIV_W'(1) : div_q;
  assign tick    = (tick_cnt == div_eff - DIV_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      div_q    <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      div_q    <= baud_div;
    end else begin
      tick_cnt <= tick_cnt + DIV_W'(1);
    end
  end

  // Receiver state
  logic [2:0]           state;
  logic [3:0]           s;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 samp7;
  logic                 samp8;
  logic [1:0]           pmode_q;
  logic                 two_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 armed;

  logic maj_bit;
  logic decide;
  logic last_tick;
  logic par_en;
  logic commit;
  logic commit_fe;

  // Majority of the samples taken at s = 7, 8 and the live one at s = 9.
  assign maj_bit   = (samp7 & samp8) | (samp7 & rx_s) | (samp8 & rx_s);
  assign decide    = tick && (s == 4'd9);
  assign last_tick = tick && (s == S_LAST);
  assign par_en    = (pmode_q == 2'b01) || (pmode_q == 2'b10);
  assign busy      = (state != ST_IDLE);

  // The frame is finished at the mid-bit decision of the last stop bit.
  always_comb begin
    commit    = 1'b0;
    commit_fe = ferr_q;
    if (decide) begin
      if (state == ST_STOP1 && !two_q) begin
        commit    = 1'b1;
        commit_fe = ~maj_bit;
      end else if (state == ST_STOP2) begin
        commit    = 1'b1;
        commit_fe = ferr_q | ~maj_bit;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      s       <= '0;
      idx     <= '0;
      shreg   <= '0;
      samp7   <= 1'b0;
      samp8   <= 1'b0;
      pmode_q <= '0;
      two_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      // A start needs a 1 seen on rx_s while idle, so a line stuck low
      // (break) cannot retrigger until it has gone high again.
      if (state == ST_IDLE) begin
        armed <= armed | rx_s;
      end else begin
        armed <= 1'b0;
      end

      if (tick && state != ST_IDLE) begin
        s <= s + 4'd1;
        if (s == 4'd7) samp7 <= rx_s;
        if (s == 4'd8) samp8 <= rx_s;
      end

      case (state)
        ST_IDLE: begin
          if (tick && armed && !rx_s) begin
            state   <= ST_START;
            s       <= '0;
            idx     <= '0;
            pmode_q <= parity_mode;
            two_q   <= two_stop;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
          end
        end
        ST_START: begin
          if (decide && maj_bit) begin
            state <= ST_IDLE;
          end else if (last_tick) begin
            state <= ST_DATA;
            idx   <= '0;
          end
        end
        ST_DATA: begin
          if (decide) begin
            shreg[idx] <= maj_bit;
          end
          if (last_tick) begin
            if (idx == LAST_IDX) begin
              state <= par_en ? ST_PARITY : ST_STOP1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        ST_PARITY: begin
          if (decide) begin
            if (pmode_q == 2'b01) begin
              perr_q <= (^shreg) ^ maj_bit;
            end else begin
              perr_q <= ~((^shreg) ^ maj_bit);
            end
          end
          if (last_tick) begin
            state <= ST_STOP1;
          end
        end
        ST_STOP1: begin
          if (decide) begin
            ferr_q <= ~maj_bit;
            // Single stop bit: return to IDLE half a bit early so a start
            // edge right after the stop bit is not missed.
            if (!two_q) begin
              state <= ST_IDLE;
            end
          end
          if (last_tick && two_q) begin
            state <= ST_STOP2;
          end
        end
        ST_STOP2: begin
          if (decide) begin
            ferr_q <= ferr_q | ~maj_bit;
            state  <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output holding register. A same-cycle handshake frees the register, so
  // a commit in that cycle is accepted rather than reported as overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= perr_q;
          frame_err  <= commit_fe;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised, oversampling UART receiver. It is the next-generation replacement for the fixed 8N1 receiver in the serial subsystem.
- Adds a runtime baud divisor, 16x oversampling with 3-sample majority vote, and false-start rejection.
- Adds configurable data width, parity and stop bits.
- Adds a valid/ready output holding register with parity, framing and overrun reporting.
- Sits between the pad-side rx line and the host register/FIFO logic.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
DIV_W, 16, width of baud_div
OSR, 16, oversample ticks per bit (fixed at 16; other values not supported)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx  in  1  serial line, asynchronous to clk, idle high
baud_div  in  DIV_W  clk cycles per oversample tick; value 0 is treated as 1
parity_mode  in  2  00 none, 01 even, 10 odd, 11 none
two_stop  in  1  0 = one stop bit, 1 = two stop bits
rx_data  out  DATA_BITS  received word, held while rx_valid is high
rx_valid  out  1  word available in the holding register
rx_ready  in  1  consumer accepts the word when rx_valid and rx_ready are both high
parity_err  out  1  parity mismatch for the held word; qualified by rx_valid
frame_err  out  1  a stop bit was sampled low for the held word; qualified by rx_valid
overrun  out  1  one-cycle pulse: a completed frame was dropped because the holding register was full
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: rx_data 0, rx_valid 0, parity_err 0, frame_err 0, overrun 0, busy 0. The synchroniser flops reset to 1; FSM goes to IDLE; all counters reset to 0.
- Reset mid-frame aborts the frame. No output activity follows reset release until a new start edge arrives.
- rx passes through a 2-flop synchroniser (rx_s) before any other logic.
- Tick generator:
  - Counter runs 0..max(baud_div,1)-1 and emits a one-clk tick on the terminal count, then wraps.
  - It runs continuously and is not restarted by the FSM.
  - Changing baud_div takes effect at the next wrap; changing it mid-frame is not supported.
- Sample counter s (4 bits) increments on each tick and wraps 15 -> 0. The bit value is the majority of rx_s at ticks s = 7, 8, 9; it is decided on the s = 9 tick.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: on a tick with rx_s = 0, go to START with s = 0.
  - START: on the s = 9 decision, if the majority is 1 (glitch), return to IDLE with no outputs. Otherwise continue; on the s = 15 tick go to DATA with bit index 0.
  - DATA: shift the majority into bit[idx] at s = 9. At s = 15, if idx = DATA_BITS-1, go to PARITY (when parity is enabled) or STOP1; otherwise idx+1.
  - PARITY: at s = 9, the parity error is (XOR of data bits XOR sampled bit) != 0 for even mode, and == 0 for odd mode. At s = 15 go to STOP1.
  - STOP1: at s = 9 record framing error = ~majority.
    - If two_stop = 1: at s = 15 go to STOP2.
    - If two_stop = 0: commit and go to IDLE immediately at the s = 9 decision, so the next start edge is not missed.
  - STOP2: at s = 9, OR ~majority into the framing error, commit, go to IDLE.
- parity_mode and two_stop are sampled on the IDLE -> START transition and held for the whole frame.
- Commit:
  - If rx_valid = 0, or a handshake (rx_valid and rx_ready) occurs in the same cycle: load rx_data and the error flags, and set rx_valid = 1 on the next clk edge. Latency is 1 clk after the deciding tick.
  - Otherwise, discard the new frame, keep the old word and flags, and pulse overrun for 1 clk.
- Handshake: rx_valid and rx_ready both high on a clk edge clears rx_valid unless a commit happens in the same cycle. rx_data and the flags are stable while rx_valid = 1.
- A frame with frame_err is still delivered, flagged. A line held low (break) produces a word of 0 with frame_err, then the FSM waits in IDLE. The next start is detected only after rx_s has returned high and then falls again; IDLE requires a 1 to 0 transition seen on rx_s.
- Data width: with DATA_BITS = 9, parity covers all 9 bits.

Test Plan:
- baud_div = 2 (32 clk/bit), 8N1, send 0xA5, rx_ready = 1 -> one rx_valid cycle with rx_data = 0xA5, parity_err = 0, frame_err = 0. rx_valid rises 1 clk after the s = 9 tick of the stop bit.
- Even parity, send 0x3C with a correct parity bit of 0, then 0x3C with parity bit 1 -> first word parity_err = 0, second word parity_err = 1, data 0x3C both times.
- two_stop = 1, second stop bit driven low, data 0x55 -> rx_data = 0x55, frame_err = 1. Repeat with both stop bits high -> frame_err = 0.
- rx low pulse of 4 clk (under half a bit) while in IDLE -> FSM returns to IDLE, no rx_valid, busy returns to 0. A 1-tick glitch on data bit 3 of 0x00 -> majority vote yields 0x00.
- rx_ready = 0, send 0x11 then 0x22 back-to-back -> rx_data stays 0x11, overrun pulses exactly once. Raise rx_ready -> 0x11 is accepted and rx_valid drops.
- Assert rst mid-DATA of 0xF0, release, then send 0x0F -> all outputs are 0 during reset and the only delivered word is 0x0F.
